// File: rtl/syscall_uart_pkg.sv
// Shared types and constants for the syscall print UART: FSM states,
// line-ending characters and the nibble-to-ASCII hex mapping.
package syscall_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam int         CHARS_PER_WORD = 10;

  // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'd0, nib};
    end
    return 8'h37 + {4'd0, nib};
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 UART transmitter. Each bit is held for DIVISOR cycles;
// o_done pulses during the final cycle of the stop bit.
module uart_byte_tx #(
  parameter int DIVISOR = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_txd,
  output logic       o_done
);

  localparam int BW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic          r_active;
  logic          w_bit_end;

  assign w_bit_end = r_active && (r_baud == BW'(DIVISOR - 1));
  assign o_done    = w_bit_end && (r_bit == 4'd9);
  // Line idles high because the shift register refills with ones.
  assign o_txd     = r_shift[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
      r_active <= 1'b0;
    end else if (!r_active) begin
      if (i_start) begin
        r_shift  <= {1'b1, i_byte, 1'b0};
        r_baud   <= '0;
        r_bit    <= '0;
        r_active <= 1'b1;
      end
    end else if (w_bit_end) begin
      r_baud  <= '0;
      r_shift <= {1'b1, r_shift[9:1]};
      r_bit   <= r_bit + 4'd1;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
      end
    end else begin
      r_baud <= r_baud + BW'(1);
    end
  end

endmodule

// File: rtl/syscall_uart_tx.sv
// Captures CPU print-syscall words into a FIFO and sends each one over UART
// as eight uppercase hex characters followed by CR LF.
module syscall_uart_tx
  import syscall_uart_pkg::*;
#(
  parameter int CLOCK_HZ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] data,
  output logic        txd,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int DIVISOR = CLOCK_HZ / BAUD;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_overflow;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [3:0]    r_idx;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic          w_start;
  logic          w_done;
  logic [7:0]    w_char;
  logic [7:0]    w_hex_char [8];

  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_pop        = (r_state == IDLE) && (r_count != '0);
  assign w_push       = valid && ((r_count != CW'(DEPTH)) || w_pop);
  assign w_drop       = valid && !w_push;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_hex
      assign w_hex_char[gi] = nibble_to_ascii(r_word[31-4*gi -: 4]);
    end
  endgenerate

  always_comb begin
    w_char = CHAR_LF;
    if (r_idx < 4'd8) begin
      w_char = w_hex_char[r_idx[2:0]];
    end else if (r_idx == 4'd8) begin
      w_char = CHAR_CR;
    end
  end

  // Start is decoded from LOAD so the start bit leaves on the LOAD edge.
  assign w_start = (r_state == LOAD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_word  <= r_mem[r_rptr];
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_state <= SEND;
        end
        SEND: begin
          if (w_done) begin
            if (r_idx == 4'(CHARS_PER_WORD - 1)) begin
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .DIVISOR(DIVISOR)
  ) u_byte_tx (
    .clock  (clock),
    .reset  (reset),
    .i_start(w_start),
    .i_byte (w_char),
    .o_txd  (txd),
    .o_done (w_done)
  );

  assign busy     = (r_state != IDLE) || (r_count != '0);
  assign full     = r_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_syscall_uart_tx.sv
// Bench for syscall_uart_tx: a line-level UART receiver decodes txd, and the
// decoded bytes are compared with hand tables and a hex-print reference model.
module tb_syscall_uart_tx;

  localparam int D     = 16;
  localparam int FRAME = 10 * D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] data  = '0;
  logic        txd;
  logic        busy;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] words[$];
  int          frames_started = 0;
  bit          mon_active = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [79:0] chars;
  } vec_t;

  vec_t tbl[3];

  syscall_uart_tx #(
    .CLOCK_HZ(16),
    .BAUD    (1),
    .DEPTH   (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .valid   (valid),
    .data    (data),
    .txd     (txd),
    .busy    (busy),
    .full    (full),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference: each word prints as 8 uppercase hex digits, MSB first, then CR LF.
  function automatic void model_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      int nib;
      nib = int'((w >> (28 - 4 * i)) & 32'hF);
      exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Receiver: samples every cycle of a frame so bit widths are checked exactly.
  initial begin : monitor
    int         cnt;
    logic [9:0] bits;
    bit         err;
    cnt  = 0;
    bits = '0;
    err  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (txd === 1'b0) begin
          mon_active = 1'b1;
          frames_started++;
          bits    = '0;
          bits[0] = 1'b0;
          err     = 1'b0;
          cnt     = 1;
        end
      end else begin
        if (cnt % D == 0) bits[cnt/D] = txd;
        else if (txd !== bits[cnt/D]) err = 1'b1;
        cnt++;
        if (cnt == FRAME) begin
          mon_active = 1'b0;
          check("frame err/start/stop", 32'({err, bits[0], bits[9]}), 32'h1);
          rx_q.push_back(bits[8:1]);
        end
      end
    end
  end

  task automatic compare_rx(input string name);
    int n;
    n = exp_q.size();
    check({name, " byte count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      check($sformatf("%s byte %0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    $display("rx %s: %0d bytes received, %0d expected", name, rx_q.size(), n);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clock);
      c++;
    end
    check({name, " idle within budget"}, 32'(busy === 1'b0), 32'h1);
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  // Pushes every word in 'words' on consecutive cycles; ends at posedge+1.
  task automatic push_burst();
    foreach (words[i]) begin
      valid = 1'b1;
      data  = words[i];
      @(posedge clock);
      #1;
    end
    valid = 1'b0;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int fs;
    int n;

    tbl[0] = '{32'hDEADBEEF, {"DEADBEEF", 8'h0D, 8'h0A}};
    tbl[1] = '{32'h01234567, {"01234567", 8'h0D, 8'h0A}};
    tbl[2] = '{32'h89ABCDEF, {"89ABCDEF", 8'h0D, 8'h0A}};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset txd", 32'(txd), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset full", 32'(full), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    check("idle no start bits", 32'(frames_started), 32'h0);
    check("idle txd", 32'(txd), 32'h1);

    // Single word: latency and busy duration
    @(posedge clock);
    #1 valid = 1'b1;
    data = 32'h0000002A;
    @(posedge clock);
    #1 valid = 1'b0;
    @(negedge clock);
    check("single busy after push", 32'(busy), 32'h1);
    @(negedge clock);
    check("single txd one cycle after push", 32'(txd), 32'h1);
    @(negedge clock);
    check("single txd two cycles after push", 32'(txd), 32'h0);
    repeat (1608) @(negedge clock);
    check("single busy before word end", 32'(busy), 32'h1);
    repeat (2) @(negedge clock);
    check("single busy at word end", 32'(busy), 32'h0);
    repeat (4) @(negedge clock);
    model_word(32'h0000002A);
    compare_rx("word 0000002A");

    // Table-driven hex coverage
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 valid = 1'b1;
      data = tbl[i].word;
      @(posedge clock);
      #1 valid = 1'b0;
      for (int j = 0; j < 10; j++) exp_q.push_back(tbl[i].chars[79-8*j -: 8]);
      wait_idle($sformatf("table %0d", i), 2000);
      compare_rx($sformatf("table %08h", tbl[i].word));
    end

    // Overflow: 10 consecutive pushes, the 10th is dropped
    do_reset();
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back($urandom);
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      data  = words[i];
      @(posedge clock);
      #1;
      if (i == 7) check("ovf full after push 8", 32'(full), 32'h0);
      if (i == 8) begin
        check("ovf full after push 9", 32'(full), 32'h1);
        check("ovf overflow after push 9", 32'(overflow), 32'h0);
      end
      if (i == 9) check("ovf overflow after push 10", 32'(overflow), 32'h1);
    end
    valid = 1'b0;
    for (int i = 0; i < 9; i++) model_word(words[i]);
    wait_idle("overflow", 9 * 1700);
    check("ovf overflow sticky", 32'(overflow), 32'h1);
    check("ovf full cleared", 32'(full), 32'h0);
    compare_rx("overflow burst");

    // Push exactly on the IDLE pop cycle while full
    do_reset();
    words.delete();
    for (int i = 0; i < 9; i++) words.push_back($urandom);
    push_burst();
    check("coinc full after 9 pushes", 32'(full), 32'h1);
    repeat (1603) @(posedge clock);
    #1;
    check("coinc full before pop cycle", 32'(full), 32'h1);
    words.push_back($urandom);
    valid = 1'b1;
    data  = words[9];
    @(posedge clock);
    #1 valid = 1'b0;
    check("coinc full after push+pop", 32'(full), 32'h1);
    check("coinc overflow after push+pop", 32'(overflow), 32'h0);
    foreach (words[i]) model_word(words[i]);
    wait_idle("coincident", 10 * 1700);
    check("coinc overflow at end", 32'(overflow), 32'h0);
    compare_rx("coincident burst");

    // Reset in bit 3 of character index 3, three words still queued
    do_reset();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    push_burst();
    repeat (535) @(posedge clock);
    #2;
    check("midframe receiver in frame", 32'(mon_active), 32'h1);
    reset = 1'b1;
    #1;
    check("midframe txd", 32'(txd), 32'h1);
    check("midframe busy", 32'(busy), 32'h0);
    check("midframe full", 32'(full), 32'h0);
    check("midframe count", 32'(dut.r_count), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    fs = frames_started;
    repeat (2000) @(negedge clock);
    check("post-reset no start bits", 32'(frames_started), 32'(fs));
    check("post-reset busy", 32'(busy), 32'h0);

    // Random bursts against the reference model
    for (int r = 0; r < 3; r++) begin
      @(posedge clock);
      #1;
      n = $urandom_range(1, 5);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      foreach (words[i]) model_word(words[i]);
      push_burst();
      wait_idle($sformatf("random %0d", r), n * 1700);
      compare_rx($sformatf("random burst %0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
